// File: rtl/lcd_value_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lcd_pkg
// Purpose  : Shared constants, state encoding and character helper for the
//            LCD value writer and its binary-to-BCD converter.
// Revision : 1.0 - initial release
// ============================================================================
package lcd_pkg;

    // Register-select bit of the 9-bit {rs,d} word
    localparam logic       RS_CMD        = 1'b0;
    localparam logic       RS_DATA       = 1'b1;

    // HD44780 command / character codes
    localparam logic [7:0] CMD_SET_DDRAM = 8'h80;
    localparam logic [7:0] ASCII_ZERO    = 8'h30;
    localparam logic [7:0] ASCII_SPACE   = 8'h20;

    // Field geometry
    localparam int         NUM_DIGITS    = 10;
    localparam int         BIN_WIDTH     = 32;
    localparam int         BCD_WIDTH     = 4 * NUM_DIGITS;

    // Sequencer states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CONV  = 3'd1,
        ISSUE = 3'd2,
        ACK   = 3'd3,
        FREE  = 3'd4
    } state_t;

    // ASCII code of one decimal digit, or a space when the digit is blanked
    function automatic logic [7:0] digit_char(input logic [3:0] digit, input logic blank);
        return blank ? ASCII_SPACE : (ASCII_ZERO + {4'h0, digit});
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_value_writer_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : bin2bcd_seq
// Purpose  : Iterative double-dabble converter, one input bit per cycle.
//            A start pulse loads the binary value; 32 shift cycles follow.
//            done is high during the cycle whose clock edge performs the
//            final shift, so bcd holds the complete result from the next
//            cycle on.
// Revision : 1.0 - initial release
// ============================================================================
module bin2bcd_seq
    import lcd_pkg::*;
(
    input  logic                 clock,
    input  logic                 internal_reset,
    input  logic                 start,
    input  logic [BIN_WIDTH-1:0] bin,
    output logic [BCD_WIDTH-1:0] bcd,
    output logic                 done
);

    localparam logic [4:0] c_LAST_SHIFT = 5'(BIN_WIDTH - 1);

    logic [BIN_WIDTH-1:0] r_bin;
    logic [BCD_WIDTH-1:0] r_bcd;
    logic [4:0]           r_count;
    logic                 r_running;
    // The top digit of a 32-bit value never exceeds 4, so it needs no add-3
    logic [BCD_WIDTH-5:0] w_adj_low;

    // Add 3 to every lower digit that is 5 or more before the next shift
    always_comb begin
        w_adj_low = r_bcd[BCD_WIDTH-5:0];
        for (int i = 0; i < NUM_DIGITS - 1; i++) begin
            if (r_bcd[4*i +: 4] > 4'd4) begin
                w_adj_low[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // Load on start, then shift one binary bit into the BCD register per cycle
    always_ff @(posedge clock) begin
        if (internal_reset) begin
            r_bin     <= '0;
            r_bcd     <= '0;
            r_count   <= '0;
            r_running <= 1'b0;
        end else if (start) begin
            r_bin     <= bin;
            r_bcd     <= '0;
            r_count   <= '0;
            r_running <= 1'b1;
        end else if (r_running) begin
            r_bcd   <= {r_bcd[BCD_WIDTH-2:BCD_WIDTH-4], w_adj_low, r_bin[BIN_WIDTH-1]};
            r_bin   <= {r_bin[BIN_WIDTH-2:0], 1'b0};
            r_count <= r_count + 5'd1;
            if (r_count == c_LAST_SHIFT) begin
                r_running <= 1'b0;
            end
        end
    end

    assign bcd  = r_bcd;
    assign done = r_running && (r_count == c_LAST_SHIFT);

endmodule
`default_nettype wire

// File: rtl/lcd_value_writer.sv
`default_nettype none
// ============================================================================
// Module   : lcd_value_writer
// Purpose  : Renders a 32-bit reading as a right-aligned 10-character
//            decimal field on one LCD line. Each refresh converts the value
//            to BCD, then streams a Set-DDRAM-address command followed by ten
//            character writes through the {rs,d} / data_ready / busy_flag
//            handshake of the lcd driver.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_value_writer
    import lcd_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned REFRESH_MS = 500,
    parameter logic [6:0]  LINE_ADDR  = 7'h00
) (
    input  logic        clock,
    input  logic        internal_reset,
    input  logic [31:0] datobase,
    input  logic        update,
    input  logic        lcd_busy,
    output logic [8:0]  d_in,
    output logic        data_ready,
    output logic        busy
);

    localparam logic [3:0] c_LAST_INDEX = 4'(NUM_DIGITS);

    state_t               r_state;
    state_t               w_state_next;
    logic [3:0]           r_index;
    logic [3:0]           w_index_next;
    logic [8:0]           r_d_in;
    logic [8:0]           w_d_in_next;
    logic                 r_busy;
    logic                 w_busy_next;
    logic                 r_pending;
    logic                 w_accept;
    logic                 w_tick;
    logic                 w_data_ready;
    logic                 w_conv_done;
    logic [BCD_WIDTH-1:0] w_bcd;

    // Word sent at a given index: 0 is the address command, 1..10 the digits
    // most significant first, with leading zeros shown as spaces except units
    function automatic logic [8:0] word_for(input logic [3:0] idx, input logic [BCD_WIDTH-1:0] bcd);
        logic       lead;
        logic [3:0] digit;
        logic [8:0] word;
        lead  = 1'b1;
        digit = 4'h0;
        for (int j = 1; j <= NUM_DIGITS; j++) begin
            if (j <= int'(idx)) begin
                digit = bcd[4*(NUM_DIGITS-j) +: 4];
                if (digit != 4'h0) begin
                    lead = 1'b0;
                end
            end
        end
        if (idx == 4'h0) begin
            word = {RS_CMD, CMD_SET_DDRAM | {1'b0, LINE_ADDR}};
        end else begin
            word = {RS_DATA, digit_char(digit, lead && (idx != c_LAST_INDEX))};
        end
        return word;
    endfunction

    // Periodic refresh request; reloads and keeps running after each expiry
    if (REFRESH_MS != 0) begin : g_timer
        localparam int unsigned c_TIMER_MAX = CLK_FREQ / 1000 * REFRESH_MS - 1;
        logic [31:0] r_timer;

        // Free-running period counter
        always_ff @(posedge clock) begin
            if (internal_reset || (r_timer == c_TIMER_MAX)) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + 32'd1;
            end
        end

        assign w_tick = (r_timer == c_TIMER_MAX);
    end else begin : g_no_timer
        assign w_tick = 1'b0;
    end

    // Serial converter; the value is sampled only on the accepting cycle
    bin2bcd_seq u_bin2bcd (
        .clock          (clock),
        .internal_reset (internal_reset),
        .start          (w_accept),
        .bin            (datobase),
        .bcd            (w_bcd),
        .done           (w_conv_done)
    );

    // Refresh requests coalesce here; acceptance wins over a same-cycle request
    always_ff @(posedge clock) begin
        if (internal_reset) begin
            r_pending <= 1'b0;
        end else if (w_accept) begin
            r_pending <= 1'b0;
        end else if (update || w_tick) begin
            r_pending <= 1'b1;
        end
    end

    // Next-state and handshake decode
    always_comb begin
        w_state_next = r_state;
        w_index_next = r_index;
        w_d_in_next  = r_d_in;
        w_busy_next  = r_busy;
        w_accept     = 1'b0;
        w_data_ready = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_pending) begin
                    w_accept     = 1'b1;
                    w_busy_next  = 1'b1;
                    w_state_next = CONV;
                end
            end
            CONV: begin
                // The command word does not depend on the digits, so it can
                // be loaded while the last shift is still in progress
                if (w_conv_done) begin
                    w_index_next = 4'h0;
                    w_d_in_next  = word_for(4'h0, w_bcd);
                    w_state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (!lcd_busy) begin
                    w_data_ready = 1'b1;
                    w_state_next = ACK;
                end
            end
            ACK: begin
                if (lcd_busy) begin
                    w_state_next = FREE;
                end
            end
            FREE: begin
                if (!lcd_busy) begin
                    if (r_index == c_LAST_INDEX) begin
                        w_busy_next  = 1'b0;
                        w_state_next = IDLE;
                    end else begin
                        w_index_next = r_index + 4'd1;
                        w_d_in_next  = word_for(r_index + 4'd1, w_bcd);
                        w_state_next = ISSUE;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Sequencer state, word index and registered outputs
    always_ff @(posedge clock) begin
        if (internal_reset) begin
            r_state <= IDLE;
            r_index <= 4'h0;
            r_d_in  <= 9'h000;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_index <= w_index_next;
            r_d_in  <= w_d_in_next;
            r_busy  <= w_busy_next;
        end
    end

    assign d_in       = r_d_in;
    assign busy       = r_busy;
    assign data_ready = w_data_ready && !internal_reset;

endmodule
`default_nettype wire

// File: tb/tb_lcd_value_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_value_writer
// Purpose  : Self-checking bench for lcd_value_writer with a simple lcd
//            driver model and an arithmetic reference for the field text.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_value_writer;

    localparam int BUSY_CYC = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        rst2;
    logic [31:0] datobase;
    logic [31:0] datobase2;
    logic        update;
    logic [8:0]  d_in;
    logic [8:0]  d_in2;
    logic        data_ready;
    logic        data_ready2;
    logic        busy;
    logic        busy2;
    logic        force_busy;
    logic        lcd_busy;
    logic        lcd_busy2;
    int          lcd_cnt    = 0;
    int          lcd_cnt2   = 0;
    int          dr_count   = 0;
    int          viol       = 0;
    logic        prev_dr    = 1'b0;
    int          cyc        = 0;
    int          first2_cyc = -1;
    int          rel_cyc    = 0;
    int          checks     = 0;
    int          errors     = 0;
    logic [8:0]  got_q[$];
    logic [8:0]  got2_q[$];

    typedef struct {
        logic [31:0] value;
        logic [8:0]  first_char;
        logic [8:0]  units;
    } vec_t;
    vec_t vecs[6];

    always #5 clk = ~clk;

    assign lcd_busy  = force_busy || (lcd_cnt != 0);
    assign lcd_busy2 = (lcd_cnt2 != 0);

    lcd_value_writer u_dut (
        .clock          (clk),
        .internal_reset (rst),
        .datobase       (datobase),
        .update         (update),
        .lcd_busy       (lcd_busy),
        .d_in           (d_in),
        .data_ready     (data_ready),
        .busy           (busy)
    );

    lcd_value_writer #(
        .CLK_FREQ   (1_000_000),
        .REFRESH_MS (2),
        .LINE_ADDR  (7'h40)
    ) u_dut2 (
        .clock          (clk),
        .internal_reset (rst2),
        .datobase       (datobase2),
        .update         (1'b0),
        .lcd_busy       (lcd_busy2),
        .d_in           (d_in2),
        .data_ready     (data_ready2),
        .busy           (busy2)
    );

    // lcd driver model: latch the word on data_ready, stay busy for a while
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (data_ready) begin
            got_q.push_back(d_in);
            dr_count <= dr_count + 1;
            lcd_cnt  <= BUSY_CYC;
        end else if (lcd_cnt != 0) begin
            lcd_cnt <= lcd_cnt - 1;
        end
        if (data_ready2) begin
            got2_q.push_back(d_in2);
            lcd_cnt2 <= BUSY_CYC;
            if (first2_cyc < 0) first2_cyc <= cyc;
        end else if (lcd_cnt2 != 0) begin
            lcd_cnt2 <= lcd_cnt2 - 1;
        end
    end

    // Handshake rule: no back-to-back pulses, never while the lcd is busy
    always @(negedge clk) begin
        if (data_ready && (prev_dr || lcd_busy)) viol <= viol + 1;
        prev_dr <= data_ready;
    end

    // Expected word idx for value v: plain decimal arithmetic
    function automatic logic [8:0] exp_word(input logic [31:0] v, input logic [6:0] a, input int idx);
        longint unsigned n;
        logic [7:0]      ch;
        if (idx == 0) return {1'b0, 1'b1, a};
        n = v;
        for (int pos = 10; pos > idx; pos--) n = n / 10;
        if (idx == 10 || n != 0) ch = 8'h30 + 8'(n % 10);
        else ch = 8'h20;
        return {1'b1, ch};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
        end
    endtask

    task automatic wait_busy(input logic level, input int limit, input string name);
        int n = 0;
        while (busy !== level && n < limit) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== level) begin
            errors++;
            $display("FAIL %s: busy stayed %b, required %b within %0d cycles", name, busy, level, limit);
        end
    endtask

    task automatic wait_words(input int n, input string name);
        int k = 0;
        while (got_q.size() < n && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check(name, got_q.size(), n);
    endtask

    task automatic pulse_update();
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
    endtask

    task automatic check_stream(input string name, input int base, input logic [31:0] v, input logic [6:0] a);
        check($sformatf("%s count", name), got_q.size() - base, 11);
        for (int i = 0; i < 11; i++) begin
            if (base + i < got_q.size())
                check($sformatf("%s word%0d", name, i), got_q[base+i], exp_word(v, a, i));
        end
    endtask

    task automatic run_refresh(input string name, input logic [31:0] v, output int base);
        base     = got_q.size();
        datobase = v;
        pulse_update();
        wait_busy(1'b1, 10, {name, " start"});
        wait_busy(1'b0, 1000, {name, " end"});
        check_stream(name, base, v, 7'h00);
    endtask

    initial begin
        #800_000;
        $display("FAIL watchdog: simulation did not finish, required finish before time limit");
        $fatal(1);
    end

    initial begin
        int base;
        int dr0;
        logic [31:0] va;

        vecs[0] = '{32'd0,          9'h120, 9'h130};
        vecs[1] = '{32'd1234567,    9'h120, 9'h137};
        vecs[2] = '{32'hFFFFFFFF,   9'h134, 9'h135};
        vecs[3] = '{32'd1000000000, 9'h131, 9'h130};
        vecs[4] = '{32'd9,          9'h120, 9'h139};
        vecs[5] = '{32'd4000000000, 9'h134, 9'h130};

        rst        = 1'b1;
        rst2       = 1'b1;
        update     = 1'b0;
        force_busy = 1'b1;
        datobase   = 32'd0;
        datobase2  = 32'hFFFFFFFF;
        repeat (3) @(negedge clk);
        check("reset d_in", d_in, 9'h000);
        check("reset data_ready", data_ready, 0);
        check("reset busy", busy, 0);
        rst  = 1'b0;
        rst2 = 1'b0;
        rel_cyc = cyc;

        // lcd still initialising: the request must wait without any pulse
        repeat (5) @(negedge clk);
        base = got_q.size();
        pulse_update();
        repeat (1000) @(negedge clk);
        check("init no data_ready", dr_count, 0);
        check("init busy held", busy, 1);
        force_busy = 1'b0;
        wait_busy(1'b0, 1000, "init end");
        check_stream("zero", base, 32'd0, 7'h00);
        check("zero d_in held", d_in, 9'h130);

        // Table of values with hand-derived first character and units digit
        for (int t = 0; t < 6; t++) begin
            run_refresh($sformatf("vec%0d", t), vecs[t].value, base);
            if (got_q.size() >= base + 11) begin
                check($sformatf("vec%0d first", t), got_q[base+1], vecs[t].first_char);
                check($sformatf("vec%0d units", t), got_q[base+10], vecs[t].units);
            end
            check($sformatf("vec%0d d_in held", t), d_in, vecs[t].units);
        end

        // Random values against the arithmetic reference
        for (int r = 0; r < 4; r++) begin
            va = (r < 2) ? $urandom() : $urandom_range(0, 99999);
            run_refresh($sformatf("rand%0d", r), va, base);
        end

        // Two requests and a value change during word 4: old value completes,
        // then exactly one refresh with the new value
        base     = got_q.size();
        datobase = 32'd5551212;
        pulse_update();
        wait_words(base + 4, "coalesce word4");
        pulse_update();
        repeat (3) @(negedge clk);
        datobase = 32'd8675309;
        pulse_update();
        wait_busy(1'b0, 1000, "coalesce first end");
        check_stream("coalesce old", base, 32'd5551212, 7'h00);
        wait_busy(1'b1, 10, "coalesce second start");
        wait_busy(1'b0, 1000, "coalesce second end");
        check_stream("coalesce new", base + 11, 32'd8675309, 7'h00);
        repeat (400) @(negedge clk);
        check("coalesce no extra", got_q.size(), base + 22);

        // Reset while the sixth word is being acknowledged
        base     = got_q.size();
        datobase = 32'd777;
        pulse_update();
        wait_words(base + 6, "reset word6");
        rst = 1'b1;
        @(negedge clk);
        check("midreset d_in", d_in, 9'h000);
        check("midreset data_ready", data_ready, 0);
        check("midreset busy", busy, 0);
        rst = 1'b0;
        dr0 = dr_count;
        repeat (300) @(negedge clk);
        check("postreset quiet", dr_count, dr0);
        check("postreset d_in", d_in, 9'h000);
        check("postreset busy", busy, 0);
        run_refresh("recover", 32'd42, base);

        check("handshake violations", viol, 0);

        // Timer-driven instance on line 2
        check("timer stream present", (got2_q.size() >= 11) ? 1 : 0, 1);
        for (int i = 0; i < 11; i++) begin
            if (i < got2_q.size())
                check($sformatf("timer word%0d", i), got2_q[i], exp_word(32'hFFFFFFFF, 7'h40, i));
        end
        check("timer first pulse window",
              ((first2_cyc - rel_cyc >= 2000) && (first2_cyc - rel_cyc <= 2100)) ? 1 : 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
